// File: rtl/gppcu_thread_regbank_mt.sv
// Multi-threaded register bank: NTHR x 2^AW words, one write port, two bypassed read ports.
// Define GPPCU_REGBANK_ZERO_REG_EN to hard-wire index 0 of every thread to zero.
module gppcu_thread_regbank_mt #(
   parameter int unsigned DW   = 32,
   parameter int unsigned AW   = 5,
   parameter int unsigned NTHR = 4,
   localparam int unsigned TW  = $clog2(NTHR)
) (
   input  logic          iACLK,
   input  logic          iARST,
   input  logic          iCLR,
   output logic          oREADY,
   input  logic [TW-1:0] iTHRSEL,
   input  logic [AW-1:0] iREGASEL,
   input  logic [AW-1:0] iREGBSEL,
   output logic [DW-1:0] oREGA,
   output logic [DW-1:0] oREGB,
   input  logic          iWR,
   input  logic [TW-1:0] iWRTHR,
   input  logic [AW-1:0] iREGDSEL,
   input  logic [DW-1:0] iREGD
);

   localparam int unsigned NREG = 1 << AW;
`ifdef GPPCU_REGBANK_ZERO_REG_EN
   localparam bit ZERO_REG = 1'b1;
`else
   localparam bit ZERO_REG = 1'b0;
`endif

   typedef enum logic {
      S_CLEAR = 1'b0,
      S_IDLE  = 1'b1
   } state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;
   logic          ready_q, ready_d;
   logic          wr_idle;
   logic          wr_en;
   logic          byp_a, byp_b;

   logic [DW-1:0] rg [NTHR][NREG];

   // Next-state: sweep one index per edge in CLEAR, wait for iCLR in IDLE
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      ready_d = ready_q;
      case (state_q)
         S_CLEAR: begin
            if (idx_q == AW'(NREG - 1)) begin
               state_d = S_IDLE;
               ready_d = 1'b1;
            end else begin
               idx_d = idx_q + AW'(1);
            end
         end
         S_IDLE: begin
            if (iCLR) begin
               state_d = S_CLEAR;
               idx_d   = '0;
               ready_d = 1'b0;
            end
         end
         default: begin
            state_d = S_CLEAR;
            idx_d   = '0;
            ready_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge iACLK or posedge iARST) begin
      if (iARST) begin
         state_q <= S_CLEAR;
         idx_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         ready_q <= ready_d;
      end
   end

   assign oREADY  = ready_q;
   assign wr_idle = (state_q == S_IDLE) && iWR;
   assign wr_en   = wr_idle && !(ZERO_REG && (iREGDSEL == '0));

   // Storage has no reset; a held iARST blocks every write so nothing completes
   always_ff @(posedge iACLK) begin
      if (!iARST) begin
         if (state_q == S_CLEAR) begin
            for (int t = 0; t < int'(NTHR); t++) begin
               rg[t][idx_q] <= '0;
            end
         end else if (wr_en) begin
            rg[iWRTHR][iREGDSEL] <= iREGD;
         end
      end
   end

   assign byp_a = wr_idle && (iWRTHR == iTHRSEL) && (iREGASEL == iREGDSEL);
   assign byp_b = wr_idle && (iWRTHR == iTHRSEL) && (iREGBSEL == iREGDSEL);

   // Read ports: zero while clearing or for a hard-wired index 0
   always_comb begin
      oREGA = '0;
      oREGB = '0;
      if (state_q == S_IDLE) begin
         oREGA = byp_a ? iREGD : rg[iTHRSEL][iREGASEL];
         oREGB = byp_b ? iREGD : rg[iTHRSEL][iREGBSEL];
         if (ZERO_REG && (iREGASEL == '0)) oREGA = '0;
         if (ZERO_REG && (iREGBSEL == '0)) oREGB = '0;
      end
   end

endmodule

// File: tb/tb_gppcu_thread_regbank_mt.sv
// Randomized bench for gppcu_thread_regbank_mt against an array model of the bank.
module tb_gppcu_thread_regbank_mt;

   localparam int DW   = 32;
   localparam int AW   = 5;
   localparam int NTHR = 4;
   localparam int NREG = 32;
`ifdef GPPCU_REGBANK_ZERO_REG_EN
   localparam bit ZERO_REG = 1'b1;
`else
   localparam bit ZERO_REG = 1'b0;
`endif

   logic          clk, rst, clr, wr;
   logic [1:0]    thr, wthr;
   logic [AW-1:0] asel, bsel, dsel;
   logic [DW-1:0] d;
   logic          ready;
   logic [DW-1:0] rega, regb;

   gppcu_thread_regbank_mt #(.DW(DW), .AW(AW), .NTHR(NTHR)) dut (
      .iACLK(clk), .iARST(rst), .iCLR(clr), .oREADY(ready),
      .iTHRSEL(thr), .iREGASEL(asel), .iREGBSEL(bsel),
      .oREGA(rega), .oREGB(regb),
      .iWR(wr), .iWRTHR(wthr), .iREGDSEL(dsel), .iREGD(d)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int            n_tests = 0;
   int            n_fail  = 0;
   logic [DW-1:0] mem [NTHR][NREG];
   int            clr_left;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected read value from the bank rules applied to the current inputs
   function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] sel);
      if (rst || clr_left > 0) return '0;
      if (ZERO_REG && sel == 0) return '0;
      if (wr && wthr == thr && sel == dsel) return d;
      return mem[thr][sel];
   endfunction

   task automatic model_edge();
      if (clr_left > 0) begin
         for (int t = 0; t < NTHR; t++) mem[t][NREG - clr_left] = '0;
         clr_left--;
      end else begin
         if (wr && !(ZERO_REG && dsel == 0)) mem[wthr][dsel] = d;
         if (clr) clr_left = NREG;
      end
   endtask

   // One clock: drive at negedge, check reads mid-cycle, check oREADY after the edge
   task automatic step(input logic w, input logic [1:0] wt, input logic [AW-1:0] ds,
                       input logic [DW-1:0] dd, input logic c, input logic [1:0] t,
                       input logic [AW-1:0] a, input logic [AW-1:0] b);
      wr = w; wthr = wt; dsel = ds; d = dd; clr = c; thr = t; asel = a; bsel = b;
      #1;
      check("rega", rega, exp_rd(a));
      check("regb", regb, exp_rd(b));
      @(posedge clk);
      if (!rst) model_edge();
      #1;
      check("ready", DW'(ready), DW'(!rst && clr_left == 0));
      @(negedge clk);
   endtask

   task automatic idle_read(input logic [1:0] t, input logic [AW-1:0] a, input logic [AW-1:0] b);
      step(1'b0, 2'd0, '0, '0, 1'b0, t, a, b);
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; wr = 1'b0; thr = '0; wthr = '0;
      asel = '0; bsel = '0; dsel = '0; d = '0;
      clr_left = NREG;
      for (int t = 0; t < NTHR; t++)
         for (int r = 0; r < NREG; r++) mem[t][r] = $urandom;
      #2;
      check("rst_ready", DW'(ready), '0);
      check("rst_rega", rega, '0);
      @(negedge clk);
      step(1'b1, 2'd1, 5'd3, 32'h1234, 1'b1, 2'd1, 5'd3, 5'd4);
      rst = 1'b0;

      // Power-up sweep: ready low 31 edges, high after edge 32
      for (int i = 0; i < NREG; i++) idle_read(2'(i % NTHR), 5'(i), 5'(NREG - 1 - i));
      for (int t = 0; t < NTHR; t++)
         for (int r = 0; r < NREG; r += 2) idle_read(2'(t), 5'(r), 5'(r + 1));

      // Same-thread bypass, then stored value
      step(1'b1, 2'd2, 5'd7, 32'hDEADBEEF, 1'b0, 2'd2, 5'd7, 5'd6);
      idle_read(2'd2, 5'd7, 5'd7);
      // No cross-thread bypass
      step(1'b1, 2'd1, 5'd3, 32'h11, 1'b0, 2'd0, 5'd0, 5'd3);
      idle_read(2'd1, 5'd2, 5'd3);

      // Random traffic with occasional clears
      for (int i = 0; i < 3000; i++) begin
         logic [AW-1:0] ra, rb, rd;
         rd = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
         ra = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 7));
         rb = 5'($urandom);
         step(1'($urandom_range(0, 1)), 2'($urandom), rd, $urandom,
              ($urandom_range(0, 199) == 0), 2'($urandom), ra, rb);
      end
      while (clr_left > 0) idle_read(2'd0, 5'd1, 5'd2);

      // Fill thread 3, then clear together with a write
      for (int r = 0; r < NREG; r++) step(1'b1, 2'd3, 5'(r), 32'hA000_0000 | r, 1'b0, 2'd3, 5'(r), 5'd4);
      step(1'b1, 2'd3, 5'd4, 32'h55, 1'b1, 2'd3, 5'd4, 5'd5);
      for (int i = 0; i < NREG; i++) step(1'b1, 2'd3, 5'd4, 32'h77, 1'b1, 2'd3, 5'd4, 5'(i));
      for (int r = 0; r < NREG; r += 2) idle_read(2'd3, 5'(r), 5'(r + 1));

      // Reset in mid-sweep restarts it from index 0
      for (int r = 0; r < 8; r++) step(1'b1, 2'd0, 5'(r), $urandom, 1'b0, 2'd0, 5'(r), 5'd0);
      step(1'b0, 2'd0, '0, '0, 1'b1, 2'd0, 5'd1, 5'd2);
      for (int i = 0; i < 10; i++) idle_read(2'd0, 5'd1, 5'd2);
      rst = 1'b1;
      clr_left = NREG;
      #1;
      check("arst_ready", DW'(ready), '0);
      for (int i = 0; i < 3; i++) step(1'b1, 2'd0, 5'd5, 32'hBAD, 1'b1, 2'd0, 5'd5, 5'd6);
      rst = 1'b0;
      for (int i = 0; i < NREG; i++) idle_read(2'd0, 5'(i), 5'd3);
      for (int r = 0; r < 8; r++) idle_read(2'd0, 5'(r), 5'(r + 8));

      // Index 0 behaviour
      step(1'b1, 2'd1, 5'd0, 32'hFFFFFFFF, 1'b0, 2'd1, 5'd0, 5'd1);
      idle_read(2'd1, 5'd0, 5'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/gppcu_thread_regbank_mt.md
GPPCU_THREAD_REGBANK_MT -- requirements
Module: gppcu_thread_regbank_mt

Interface
REQ-001 Parameter DW, default 32, data width per register.
REQ-002 Parameter AW, default 5, register index width; each thread owns 2^AW registers.
REQ-003 Parameter NTHR, default 4, thread count (power of two, >=2); TW = log2(NTHR).
REQ-004 iACLK  input  1  sole clock; all state changes on rising edge.
REQ-005 iARST  input  1  reset, asynchronous, active-high.
REQ-006 iCLR  input  1  single-cycle request to zero all registers of all threads.
REQ-007 oREADY  output  1  registered; high when bank accepts writes and returns valid reads.
REQ-008 iTHRSEL  input  TW  thread selected for both read ports.
REQ-009 iREGASEL  input  AW  read-port A index.
REQ-010 iREGBSEL  input  AW  read-port B index.
REQ-011 oREGA  output  DW  read-port A data, combinational.
REQ-012 oREGB  output  DW  read-port B data, combinational.
REQ-013 iWR  input  1  write strobe from write-back stage.
REQ-014 iWRTHR  input  TW  write thread.
REQ-015 iREGDSEL  input  AW  write index.
REQ-016 iREGD  input  DW  write data.

Function
REQ-017 Storage: NTHR x 2^AW words of DW bits; one write port, two read ports.
REQ-018 FSM states: CLEAR, IDLE; no other states.
REQ-019 IDLE, iWR=1: rg[iWRTHR][iREGDSEL] <= iREGD at the rising edge; zero-latency read-after-write.
REQ-020 Bypass: in IDLE, if iWR=1, iWRTHR==iTHRSEL and iREGASEL==iREGDSEL, oREGA=iREGD same cycle; identical rule for port B.
REQ-021 Without a bypass match, oREGx = rg[iTHRSEL][iREGxSEL]; a write to another thread never bypasses.
REQ-022 CLEAR: a AW-bit index counter zeroes word [idx] of every thread per edge, idx increments 0..2^AW-1, no wrap.
REQ-023 CLEAR -> IDLE on the edge that writes idx=2^AW-1; oREADY rises on that same edge (2^AW edges total).
REQ-024 IDLE -> CLEAR on an edge with iCLR=1; idx loads 0, oREADY falls on that edge; clearing begins next edge.
REQ-025 iCLR=1 and iWR=1 on the same IDLE edge: the write is performed, then the clear sweep overwrites it.
REQ-026 In CLEAR, iWR and iCLR are ignored; oREGA and oREGB drive 0; no bypass.
REQ-027 Sweep is never restarted by iCLR; only iARST restarts it from idx 0.

Reset
REQ-028 iARST=1 forces immediately: state CLEAR, idx 0, oREADY 0; oREGA/oREGB read 0.
REQ-029 Storage array has no reset term; it is zeroed by the sweep after iARST falls.
REQ-030 iARST asserted mid-sweep or mid-write: no write completes, sweep restarts at idx 0 after release.

Configuration
REQ-031 Macro GPPCU_REGBANK_ZERO_REG_EN defined: index 0 of every thread reads 0, writes to index 0 are discarded, no bypass for index 0.
REQ-032 Macro undefined: index 0 is an ordinary register, identical to all others.

Verification
REQ-033 AW=5: release iARST, count edges -> oREADY=0 for 31 edges, 1 after edge 32; all 128 words read 0.
REQ-034 IDLE, write thr 2 idx 7 = 0xDEADBEEF, same cycle iTHRSEL=2, iREGASEL=7 -> oREGA=0xDEADBEEF same cycle; next cycle still 0xDEADBEEF.
REQ-035 Write thr 1 idx 3 = 0x11, read thr 0 idx 3 same cycle -> oREGB=0 (no cross-thread bypass); thr 1 idx 3 later reads 0x11.
REQ-036 Fill thr 3, pulse iCLR with iWR to idx 4 = 0x55 -> oREADY low 32 edges, oREGA=0 during sweep, then all thr 3 words read 0.
REQ-037 Assert iARST at sweep idx 10 -> oREADY stays 0, sweep restarts; oREADY rises exactly 32 edges after release.
REQ-038 With GPPCU_REGBANK_ZERO_REG_EN: write idx 0 = 0xFFFFFFFF -> oREGA=0 same and next cycle; without the macro -> 0xFFFFFFFF.
